// File: rtl/script_wait_unit.sv
`default_nettype none
// ============================================================================
// Module   : script_wait_unit
// Purpose  : Wait engine for the script executor. Supports timed waits and
//            wait-until-high/low on a feedback bit, with start/busy/done and abort.
// Options  : WAIT_TIMEOUT_EN adds a waituntil timeout (TIMEOUT_MS).
// Revision : 1.0
// ============================================================================
module script_wait_unit #(
  parameter int NUM_W      = 8,
  parameter int SIG_W      = 8,
  parameter int SEL_W      = 3,
  parameter int CLK_PER_MS = 100000,
  parameter int UNIT_MS    = 100,
  parameter int TIMEOUT_MS = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       func,
  input  logic [NUM_W-1:0] i_num,
  input  logic [SEL_W-1:0] sig_sel,
  input  logic [SIG_W-1:0] feedback_sig,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             timed_out
);

  localparam int PS_W = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
  localparam int MS_W = NUM_W + $clog2(UNIT_MS) + 1;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_MS - 1);
  localparam logic [MS_W-1:0] UNIT_W  = MS_W'(UNIT_MS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TIMED = 2'd1;
  localparam logic [1:0] S_UNTIL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] F_TIMED = 2'b00;
  localparam logic [1:0] F_HIGH  = 2'b01;
  localparam logic [1:0] F_LOW   = 2'b10;

  if (((1 << SEL_W) > SIG_W) || (CLK_PER_MS < 2) || (TIMEOUT_MS < 1)) begin : g_param_check
    $error("script_wait_unit: invalid parameter combination");
  end

  logic [1:0]       state_q, state_d;
  logic [1:0]       func_q, func_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [PS_W-1:0]  presc_q, presc_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic             aborted_q, aborted_d;

  logic             tick;
  logic             cond_met;
  logic [MS_W-1:0]  target;

  assign tick     = (presc_q == PS_LAST);
  // Full-width product: no truncation of i_num * UNIT_MS.
  assign target   = MS_W'(num_q) * UNIT_W;
  assign cond_met = (func_q == F_HIGH) ? feedback_sig[sel_q] : !feedback_sig[sel_q];

`ifdef WAIT_TIMEOUT_EN
  localparam logic [MS_W-1:0] TO_LAST = MS_W'(TIMEOUT_MS - 1);
  logic timed_out_q, timed_out_d;
`endif

  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    num_d     = num_q;
    sel_d     = sel_q;
    presc_d   = presc_q;
    ms_d      = ms_q;
    aborted_d = 1'b0;
`ifdef WAIT_TIMEOUT_EN
    timed_out_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // A start coinciding with abort is dropped.
        if (start && !abort) begin
          func_d  = func;
          num_d   = i_num;
          sel_d   = sig_sel;
          presc_d = '0;
          ms_d    = '0;
          case (func)
            F_TIMED:       state_d = (i_num == '0) ? S_DONE : S_TIMED;
            F_HIGH, F_LOW: state_d = S_UNTIL;
            default:       state_d = S_DONE;
          endcase
        end
      end
      S_TIMED: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) ms_d = ms_q + 1'b1;
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (tick && (ms_q == target - 1'b1)) begin
          state_d = S_DONE;
        end
      end
      S_UNTIL: begin
`ifdef WAIT_TIMEOUT_EN
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) ms_d = ms_q + 1'b1;
`endif
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (cond_met) begin
          state_d = S_DONE;
`ifdef WAIT_TIMEOUT_EN
        end else if (tick && (ms_q == TO_LAST)) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      func_q    <= '0;
      num_q     <= '0;
      sel_q     <= '0;
      presc_q   <= '0;
      ms_q      <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      num_q     <= num_d;
      sel_q     <= sel_d;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef WAIT_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timed_out_q <= 1'b0;
    else     timed_out_q <= timed_out_d;
  end
  assign timed_out = timed_out_q;
`else
  assign timed_out = 1'b0;
`endif

  assign busy    = (state_q == S_TIMED) || (state_q == S_UNTIL);
  assign done    = (state_q == S_DONE);
  assign aborted = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_script_wait_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_script_wait_unit
// Purpose  : Self-checking bench for script_wait_unit (vector table, directed
//            corner sequences, randomized commands vs. a latency model).
// Revision : 1.0
// ============================================================================
module tb_script_wait_unit;

  localparam int CPM  = 4;
  localparam int UMS  = 2;
  localparam int TOMS = 5;

  localparam int KD = 0;
  localparam int KA = 1;
  localparam int KT = 2;

  typedef struct {
    logic [1:0] f;
    logic [7:0] n;
    logic [2:0] s;
    int         rise;
    int         ab;
    int         e;
    int         kind;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] func = 2'b00;
  logic [7:0] i_num = 8'd0;
  logic [2:0] sig_sel = 3'd0;
  logic [7:0] feedback_sig = 8'd0;
  logic       abort = 1'b0;
  logic       busy, done, aborted, timed_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  script_wait_unit #(
    .NUM_W(8), .SIG_W(8), .SEL_W(3),
    .CLK_PER_MS(CPM), .UNIT_MS(UMS), .TIMEOUT_MS(TOMS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .i_num(i_num),
    .sig_sel(sig_sel), .feedback_sig(feedback_sig), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .timed_out(timed_out)
  );

  task automatic chk(input string nm, input int k, input logic [3:0] exp_v);
    logic [3:0] act;
    act = {busy, done, aborted, timed_out};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: busy/done/aborted/timed_out=%b expected %b", nm, k, act, exp_v);
    end
  endtask

  // Completion edge (relative to E0) and outcome, from the wait rules.
  task automatic model(input logic [1:0] f, input logic [7:0] n, input int rise,
                       input int ab, output int e, output int kind);
    kind = KD;
    if (f == 2'b00)      e = int'(n) * UMS * CPM;
    else if (f == 2'b11) e = 0;
    else begin
      e = (rise < 1) ? 1 : rise;
`ifdef WAIT_TIMEOUT_EN
      if (e > TOMS * CPM) begin
        e    = TOMS * CPM;
        kind = KT;
      end
`endif
    end
    if (ab >= 1 && ab <= e) begin
      e    = ab;
      kind = KA;
    end
  endtask

  task automatic run_cmd(input string nm, input vec_t v);
    logic [7:0] fbv;
    logic       tv;
    logic [3:0] exp_v;
    int         last;
    int         start_lim;
    tv        = (v.f == 2'b01);
    last      = v.e + 1;
    start_lim = (v.kind == KA) ? v.e : v.e + 1;
    start = 1'b1; func = v.f; i_num = v.n; sig_sel = v.s; abort = 1'b0;
    feedback_sig = 8'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (k < v.e)       exp_v = 4'b1000;
      else if (k == v.e) exp_v = {1'b0, v.kind != KA, v.kind == KA, v.kind == KT};
      else               exp_v = 4'b0000;
      chk(nm, k, exp_v);
      if (k == last) break;
      fbv = 8'($urandom);
      if (v.f == 2'b01 || v.f == 2'b10) fbv[v.s] = (k + 1 >= v.rise) ? tv : !tv;
      feedback_sig = fbv;
      abort   = (k + 1 == v.ab);
      start   = (k + 1 <= start_lim) && ($urandom_range(0, 3) == 0);
      func    = 2'($urandom);
      i_num   = 8'($urandom);
      sig_sel = 3'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    tbl.push_back('{2'd0, 8'd3, 3'd0, 0,  0,  24, KD});
    tbl.push_back('{2'd0, 8'd0, 3'd0, 0,  0,  0,  KD});
    tbl.push_back('{2'd3, 8'd5, 3'd0, 0,  0,  0,  KD});
    tbl.push_back('{2'd0, 8'd1, 3'd0, 0,  0,  8,  KD});
    tbl.push_back('{2'd1, 8'd0, 3'd4, 10, 0,  10, KD});
    tbl.push_back('{2'd1, 8'd0, 3'd4, 0,  0,  1,  KD});
    tbl.push_back('{2'd2, 8'd0, 3'd2, 7,  7,  7,  KA});
    tbl.push_back('{2'd2, 8'd0, 3'd3, 0,  0,  1,  KD});
    tbl.push_back('{2'd0, 8'd2, 3'd0, 0,  16, 16, KA});
    tbl.push_back('{2'd1, 8'd0, 3'd5, 20, 0,  20, KD});
    tbl.push_back('{2'd0, 8'd1, 3'd0, 0,  9,  8,  KD});
    tbl.push_back('{2'd0, 8'd3, 3'd0, 0,  1,  1,  KA});
`ifdef WAIT_TIMEOUT_EN
    tbl.push_back('{2'd1, 8'd0, 3'd5, 1000, 0, 20, KT});
`endif

    @(posedge clk); #7;
    chk("reset", 0, 4'b0000);
    rst = 1'b0;

    foreach (tbl[i]) run_cmd($sformatf("vec%0d", i), tbl[i]);

    // Abort in IDLE drops a simultaneous start.
    start = 1'b1; abort = 1'b1; func = 2'b00; i_num = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("idle_abort", k, 4'b0000);
      @(posedge clk); #1;
    end

`ifndef WAIT_TIMEOUT_EN
    // Without timeout the until-wait holds indefinitely.
    start = 1'b1; func = 2'b01; sig_sel = 3'd5; feedback_sig = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 120; k++) begin
      chk("hold_no_timeout", k, 4'b1000);
      feedback_sig = 8'($urandom) & 8'hDF;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("hold_abort", 0, 4'b0010);
    @(posedge clk); #1;
    chk("hold_abort", 1, 4'b0000);
`endif

    // Asynchronous reset mid-TIMED, then a clean restart.
    start = 1'b1; func = 2'b00; i_num = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_busy", 0, 4'b1000);
    #2 rst = 1'b1;
    #1 chk("async_rst", 0, 4'b0000);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst", 0, 4'b0000);
    run_cmd("rst_then_timed", tbl[0]);

    for (int i = 0; i < 40; i++) begin
      rv.f    = 2'($urandom_range(0, 3));
      rv.n    = 8'($urandom_range(0, 4));
      rv.s    = 3'($urandom_range(0, 7));
      rv.rise = $urandom_range(0, 40);
      rv.ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 45) : 0;
      model(rv.f, rv.n, rv.rise, rv.ab, rv.e, rv.kind);
      run_cmd($sformatf("rand%0d", i), rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
